dffrsnq_preload_seq: RTL and testbench



---
 rtl/dffrsnq_preload_seq.sv | 140 ++++++++++++++
 tb/tb_dffrsnq_preload_seq.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dffrsnq_preload_seq.sv
// Sequencer that preloads a bank of set/reset flops through their async SETN/RN pins.
// Define DFFRSNQ_PRELOAD_VERIFY_EN to add a one-cycle readback check (BANK_Q vs. latched value, sticky ERR).
module dffrsnq_preload_seq #(
   parameter int WIDTH           = 8,
   parameter int PULSE_CYCLES    = 2,
   parameter int RECOVERY_CYCLES = 2
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic             REQ,
   input  logic [WIDTH-1:0] VALUE,
   output logic             BUSY,
   output logic             ACK,
   output logic [WIDTH-1:0] BANK_SETN,
   output logic [WIDTH-1:0] BANK_RN,
   output logic             BANK_HOLD,
   input  logic [WIDTH-1:0] BANK_Q,
   output logic             ERR
);

   localparam int MAXC = (PULSE_CYCLES > RECOVERY_CYCLES) ? PULSE_CYCLES : RECOVERY_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] P_LOAD = CW'(PULSE_CYCLES - 1);
   localparam logic [CW-1:0] R_LOAD = CW'(RECOVERY_CYCLES - 1);

`ifdef DFFRSNQ_PRELOAD_VERIFY_EN
   typedef enum logic [2:0] {S_IDLE, S_ASSERT, S_RELEASE, S_VERIFY, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_ASSERT, S_RELEASE, S_DONE} state_t;
`endif

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] val_q, val_d;
   logic [WIDTH-1:0] setn_q, setn_d, rn_q, rn_d;
   logic             busy_q, busy_d, ack_q, ack_d, hold_q, hold_d;
   logic             err_q, err_d;
   logic             rst_sync_q;

   // Async-assert/sync-deassert: this flop is the first stage and the IDLE->ASSERT
   // state flop is the second, so REQ is first accepted on the second edge after RN rises.
   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) rst_sync_q <= 1'b0;
      else     rst_sync_q <= 1'b1;
   end

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         val_q   <= '0;
         setn_q  <= '1;
         rn_q    <= '1;
         busy_q  <= 1'b0;
         ack_q   <= 1'b0;
         hold_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         val_q   <= val_d;
         setn_q  <= setn_d;
         rn_q    <= rn_d;
         busy_q  <= busy_d;
         ack_q   <= ack_d;
         hold_q  <= hold_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      val_d   = val_q;
      err_d   = err_q;
      case (state_q)
         S_IDLE: begin
            if (REQ && rst_sync_q) begin
               state_d = S_ASSERT;
               val_d   = VALUE;
               cnt_d   = P_LOAD;
               err_d   = 1'b0;
            end
         end
         S_ASSERT: begin
            if (cnt_q == '0) begin
               state_d = S_RELEASE;
               cnt_d   = R_LOAD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         S_RELEASE: begin
            if (cnt_q == '0) begin
`ifdef DFFRSNQ_PRELOAD_VERIFY_EN
               state_d = S_VERIFY;
`else
               state_d = S_DONE;
`endif
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
`ifdef DFFRSNQ_PRELOAD_VERIFY_EN
         S_VERIFY: begin
            if (BANK_Q != val_q) err_d = 1'b1;
            state_d = S_DONE;
         end
`endif
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so every bank pin leaves a flop.
      setn_d = '1;
      rn_d   = '1;
      if (state_d == S_ASSERT) begin
         setn_d = ~val_d;
         rn_d   = val_d;
      end
      busy_d = (state_d != S_IDLE);
      ack_d  = (state_d == S_DONE);
      hold_d = (state_d != S_IDLE) && (state_d != S_DONE);
   end

   assign BUSY      = busy_q;
   assign ACK       = ack_q;
   assign BANK_SETN = setn_q;
   assign BANK_RN   = rn_q;
   assign BANK_HOLD = hold_q;

`ifdef DFFRSNQ_PRELOAD_VERIFY_EN
   assign ERR = err_q;
`else
   logic unused_readback;
   assign unused_readback = ^{BANK_Q, err_q};
   assign ERR = 1'b0;
`endif

endmodule

// File: tb/tb_dffrsnq_preload_seq.sv
// Directed bench for dffrsnq_preload_seq with a behavioural set/reset bank on the outputs.
module tb_dffrsnq_preload_seq;

   localparam int W = 8;
`ifdef DFFRSNQ_PRELOAD_VERIFY_EN
   localparam int VER = 1;
`else
   localparam int VER = 0;
`endif
   localparam int ACK_C = 5 + VER;  // P=2, R=2

   logic         CLK = 1'b0;
   logic         RN = 1'b0;
   logic         REQ = 1'b0;
   logic [W-1:0] VALUE = '0;
   logic         BUSY, ACK, BANK_HOLD, ERR;
   logic [W-1:0] BANK_SETN, BANK_RN, BANK_Q;
   logic [W-1:0] bank_q = '0;
   logic         force_en = 1'b0;
   logic [W-1:0] force_val = '0;

   int checks = 0;
   int errors = 0;
   int viol = 0;

   always #5 CLK = ~CLK;

   dffrsnq_preload_seq #(.WIDTH(W), .PULSE_CYCLES(2), .RECOVERY_CYCLES(2)) dut (
      .CLK(CLK), .RN(RN), .REQ(REQ), .VALUE(VALUE), .BUSY(BUSY), .ACK(ACK),
      .BANK_SETN(BANK_SETN), .BANK_RN(BANK_RN), .BANK_HOLD(BANK_HOLD),
      .BANK_Q(BANK_Q), .ERR(ERR)
   );

   // Async set/reset bank; clock is always gated during preload so only the pins matter.
   always @(BANK_SETN or BANK_RN) begin
      for (int i = 0; i < W; i++) begin
         if (!BANK_RN[i])        bank_q[i] = 1'b0;
         else if (!BANK_SETN[i]) bank_q[i] = 1'b1;
      end
   end
   assign BANK_Q = force_en ? force_val : bank_q;

   always @(negedge CLK) if (|(~BANK_SETN & ~BANK_RN)) viol++;

   task automatic step;
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_ack(output int cyc);
      cyc = -1;
      for (int i = 1; i <= 40; i++) begin
         step();
         if (ACK) begin cyc = i; break; end
      end
   endtask

   task automatic test_reset;
      int cyc;
      RN = 1'b0; REQ = 1'b1; VALUE = 8'hA5;
      repeat (2) step();
      checks++;
      if (BANK_SETN !== 8'hFF || BANK_RN !== 8'hFF) begin
         errors++; $display("FAIL reset_pins setn=%h rn=%h want ff ff", BANK_SETN, BANK_RN);
      end
      checks++;
      if ({BUSY, ACK, BANK_HOLD, ERR} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl busy/ack/hold/err=%b want 0000", {BUSY, ACK, BANK_HOLD, ERR});
      end
      RN = 1'b1;
      step();
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL sync_edge1 busy=%b want 0", BUSY); end
      step();
      checks++;
      if (BUSY !== 1'b1) begin errors++; $display("FAIL sync_edge2 busy=%b want 1", BUSY); end
      REQ = 1'b0;
      wait_ack(cyc);
      checks++;
      if (cyc < 0) begin errors++; $display("FAIL sync_ack timeout got %0d want ack", cyc); end
      step();
   endtask

   task automatic test_basic;
      logic [W-1:0] es, er;
      REQ = 1'b1; VALUE = 8'hA5;
      step();
      REQ = 1'b0; VALUE = 8'h00;
      for (int c = 1; c <= ACK_C; c++) begin
         es = (c <= 2) ? 8'h5A : 8'hFF;
         er = (c <= 2) ? 8'hA5 : 8'hFF;
         checks++;
         if (BANK_SETN !== es || BANK_RN !== er) begin
            errors++; $display("FAIL basic_pins c%0d setn=%h rn=%h want %h %h", c, BANK_SETN, BANK_RN, es, er);
         end
         checks++;
         if (BANK_HOLD !== (c < ACK_C) || ACK !== (c == ACK_C) || BUSY !== 1'b1 || ERR !== 1'b0) begin
            errors++; $display("FAIL basic_ctrl c%0d hold=%b ack=%b busy=%b err=%b want %b %b 1 0",
                               c, BANK_HOLD, ACK, BUSY, ERR, c < ACK_C, c == ACK_C);
         end
         if (c < ACK_C) step();
      end
      checks++;
      if (BANK_Q !== 8'hA5) begin errors++; $display("FAIL basic_bank got %h want a5", BANK_Q); end
      step();
      checks++;
      if (BUSY !== 1'b0 || ACK !== 1'b0) begin
         errors++; $display("FAIL basic_end busy=%b ack=%b want 0 0", BUSY, ACK);
      end
   endtask

   task automatic test_back_to_back;
      int cyc;
      REQ = 1'b1; VALUE = 8'h00;
      step();
      VALUE = 8'hFF;
      checks++;
      if (BANK_SETN !== 8'hFF || BANK_RN !== 8'h00) begin
         errors++; $display("FAIL b2b_zero setn=%h rn=%h want ff 00", BANK_SETN, BANK_RN);
      end
      repeat (ACK_C - 1) step();
      checks++;
      if (ACK !== 1'b1 || BANK_Q !== 8'h00) begin
         errors++; $display("FAIL b2b_ack1 ack=%b bank=%h want 1 00", ACK, BANK_Q);
      end
      step();
      checks++;
      if (BUSY !== 1'b0) begin errors++; $display("FAIL b2b_gap busy=%b want 0", BUSY); end
      step();
      checks++;
      if (BUSY !== 1'b1 || BANK_SETN !== 8'h00 || BANK_RN !== 8'hFF) begin
         errors++; $display("FAIL b2b_ones busy=%b setn=%h rn=%h want 1 00 ff", BUSY, BANK_SETN, BANK_RN);
      end
      REQ = 1'b0;
      wait_ack(cyc);
      checks++;
      if (cyc != ACK_C - 1 || BANK_Q !== 8'hFF) begin
         errors++; $display("FAIL b2b_ack2 cyc=%0d bank=%h want %0d ff", cyc, BANK_Q, ACK_C - 1);
      end
      step();
   endtask

   task automatic test_busy_reject;
      int acks = 0;
      REQ = 1'b1; VALUE = 8'hA5;
      step();
      REQ = 1'b0;
      step();
      REQ = 1'b1; VALUE = 8'h3C;
      checks++;
      if (BANK_SETN !== 8'h5A || BANK_RN !== 8'hA5) begin
         errors++; $display("FAIL rej_pins setn=%h rn=%h want 5a a5", BANK_SETN, BANK_RN);
      end
      step();
      REQ = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (ACK) acks++;
         step();
      end
      checks++;
      if (acks != 1 || BANK_Q !== 8'hA5) begin
         errors++; $display("FAIL rej_result acks=%0d bank=%h want 1 a5", acks, BANK_Q);
      end
   endtask

   task automatic test_midreset;
      int acks = 0;
      int cyc;
      int n;
      REQ = 1'b1; VALUE = 8'h5A;
      step();
      REQ = 1'b0;
      step();
      RN = 1'b0;
      #1;
      checks++;
      if (BANK_SETN !== 8'hFF || BANK_RN !== 8'hFF || {BUSY, ACK, BANK_HOLD, ERR} !== 4'b0000) begin
         errors++; $display("FAIL midrst_out setn=%h rn=%h b/a/h/e=%b want ff ff 0000",
                            BANK_SETN, BANK_RN, {BUSY, ACK, BANK_HOLD, ERR});
      end
      for (int i = 0; i < 4; i++) begin
         if (ACK) acks++;
         step();
      end
      RN = 1'b1;
      for (int i = 0; i < 6; i++) begin
         if (ACK) acks++;
         step();
      end
      checks++;
      if (acks != 0) begin errors++; $display("FAIL midrst_noack acks=%0d want 0", acks); end
      REQ = 1'b1; VALUE = 8'h3C;
      n = 0;
      while (!BUSY && n < 5) begin step(); n++; end
      REQ = 1'b0;
      checks++;
      if (n != 1) begin errors++; $display("FAIL midrst_accept edges=%0d want 1", n); end
      wait_ack(cyc);
      checks++;
      if (cyc != ACK_C - 1 || BANK_Q !== 8'h3C) begin
         errors++; $display("FAIL midrst_redo cyc=%0d bank=%h want %0d 3c", cyc, BANK_Q, ACK_C - 1);
      end
      step();
   endtask

   task automatic test_verify;
      int cyc;
      force_en = 1'b1; force_val = 8'hA4;
      REQ = 1'b1; VALUE = 8'hA5;
      step();
      REQ = 1'b0;
      wait_ack(cyc);
      checks++;
      if (ERR !== VER[0]) begin errors++; $display("FAIL verify_set err=%b want %b", ERR, VER[0]); end
      repeat (3) step();
      checks++;
      if (ERR !== VER[0]) begin errors++; $display("FAIL verify_hold err=%b want %b", ERR, VER[0]); end
      force_en = 1'b0;
      REQ = 1'b1; VALUE = 8'hC3;
      step();
      REQ = 1'b0;
      checks++;
      if (ERR !== 1'b0) begin errors++; $display("FAIL verify_clear err=%b want 0", ERR); end
      wait_ack(cyc);
      checks++;
      if (ERR !== 1'b0 || BANK_Q !== 8'hC3) begin
         errors++; $display("FAIL verify_match err=%b bank=%h want 0 c3", ERR, BANK_Q);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_busy_reject();
      test_midreset();
      test_verify();
      checks++;
      if (viol != 0) begin errors++; $display("FAIL setn_rn_overlap count=%0d want 0", viol); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

endmodule
